// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the write-through data cache and main memory.
// In-order drain over valid/ready, read forwarding of buffered stores, and tail coalescing.
module store_write_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_en_i,
    input  logic [ADDR_WIDTH-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o,
    input  logic                      rd_en_i,
    input  logic [ADDR_WIDTH-1:0]     rd_addr_i,
    output logic                      fwd_hit_o,
    output logic [DATA_WIDTH-1:0]     fwd_data_o,
    output logic                      mem_wr_valid_o,
    output logic [ADDR_WIDTH-1:0]     mem_wr_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wr_data_o,
    input  logic                      mem_wr_ready_i,
    output logic                      overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;

    logic                  full;
    logic                  empty;
    logic [PTR_W-1:0]      youngest;
    logic                  coalesce;
    logic                  enq;
    logic                  deq;
    logic                  drop;
    logic [CNT_W-1:0]      count_next;
    logic [PTR_W-1:0]      fwd_idx;
    logic                  unused_rd_offset;

    assign unused_rd_offset = ^rd_addr_i[1:0];

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign youngest = tail_q - PTR_W'(1);

    // count>=2 guarantees the youngest entry is not the head, which may be mid-handshake
    assign coalesce = wr_en_i && (count_q >= CNT_W'(2)) &&
                      (addr_q[youngest][ADDR_WIDTH-1:2] == wr_addr_i[ADDR_WIDTH-1:2]);
    assign enq      = wr_en_i && !coalesce && !full;
    assign drop     = wr_en_i && !coalesce && full;
    assign deq      = !empty && mem_wr_ready_i;

    always_comb begin
        count_next = count_q;
        if (enq && !deq) begin
            count_next = count_q + CNT_W'(1);
        end else if (deq && !enq) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= drop;
            count_q    <= count_next;
            // enq and deq never target the same slot: that needs count 0 or DEPTH
            if (deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (enq) begin
                addr_q[tail_q]  <= wr_addr_i;
                data_q[tail_q]  <= wr_data_i;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end else if (coalesce) begin
                data_q[youngest] <= wr_data_i;
            end
        end
    end

    // Oldest-to-youngest scan so the last match wins
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_idx    = '0;
        if (rd_en_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx = head_q + PTR_W'(i);
                if (valid_q[fwd_idx] &&
                    addr_q[fwd_idx][ADDR_WIDTH-1:2] == rd_addr_i[ADDR_WIDTH-1:2]) begin
                    fwd_hit_o  = 1'b1;
                    fwd_data_o = data_q[fwd_idx];
                end
            end
        end
    end

    assign full_o         = full;
    assign empty_o        = empty;
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign mem_wr_valid_o = !empty;
    assign mem_wr_addr_o  = empty ? '0 : addr_q[head_q];
    assign mem_wr_data_o  = empty ? '0 : data_q[head_q];

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: drain order, coalescing, forwarding,
// overflow and asynchronous reset, with hand-computed expectations.
module tb_store_write_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [31:0] wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic        full_o;
    logic        empty_o;
    logic [2:0]  count_o;
    logic        rd_en_i = 1'b0;
    logic [31:0] rd_addr_i = '0;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic        mem_wr_valid_o;
    logic [31:0] mem_wr_addr_o;
    logic [31:0] mem_wr_data_o;
    logic        mem_wr_ready_i = 1'b0;
    logic        overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    store_write_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
        .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
        .mem_wr_valid_o(mem_wr_valid_o), .mem_wr_addr_o(mem_wr_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_wr_ready_i(mem_wr_ready_i),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a, input logic en, input logic hit, input logic [31:0] d, input string tag);
        rd_en_i   = en;
        rd_addr_i = a;
        #1;
        check({tag, "_hit"}, 64'(fwd_hit_o), 64'(hit));
        check({tag, "_data"}, 64'(fwd_data_o), 64'(d));
        rd_en_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid", 64'(mem_wr_valid_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        check("rst_addr", 64'(mem_wr_addr_o), 64'd0);
        lookup(32'h0, 1'b1, 1'b0, 32'h0, "rst_fwd");
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // 1: single store, one-cycle latency, accepted
        mem_wr_ready_i = 1'b1;
        store(32'h100, 32'h11);
        check("t1_valid", 64'(mem_wr_valid_o), 64'd1);
        check("t1_addr", 64'(mem_wr_addr_o), 64'h100);
        check("t1_data", 64'(mem_wr_data_o), 64'h11);
        check("t1_count", 64'(count_o), 64'd1);
        tick();
        check("t1_empty", 64'(empty_o), 64'd1);
        check("t1_valid_lo", 64'(mem_wr_valid_o), 64'd0);

        // 2: fill, overflow, in-order drain
        mem_wr_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) store(32'(i * 4), 32'hA0 + 32'(i));
        check("t2_full", 64'(full_o), 64'd1);
        check("t2_count", 64'(count_o), 64'd4);
        store(32'h10, 32'hFF);
        check("t2_ovf", 64'(overflow_o), 64'd1);
        check("t2_count_ovf", 64'(count_o), 64'd4);
        mem_wr_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_addr", 64'(mem_wr_addr_o), 64'(i * 4));
            check("t2_drain_data", 64'(mem_wr_data_o), 64'hA0 + 64'(i));
            tick();
            if (i == 0) check("t2_ovf_lo", 64'(overflow_o), 64'd0);
        end
        check("t2_empty", 64'(empty_o), 64'd1);

        // 3: coalesce into youngest, never into head
        mem_wr_ready_i = 1'b0;
        store(32'h20, 32'h1);
        store(32'h24, 32'h2);
        store(32'h24, 32'h3);
        check("t3_count", 64'(count_o), 64'd2);
        mem_wr_ready_i = 1'b1;
        check("t3_d1", 64'(mem_wr_data_o), 64'h1);
        tick();
        check("t3_d3_addr", 64'(mem_wr_addr_o), 64'h24);
        check("t3_d3", 64'(mem_wr_data_o), 64'h3);
        tick();
        check("t3_empty", 64'(empty_o), 64'd1);
        mem_wr_ready_i = 1'b0;
        store(32'h30, 32'h5);
        store(32'h30, 32'h6);
        check("t3_head_nomerge", 64'(count_o), 64'd2);
        check("t3_head_data", 64'(mem_wr_data_o), 64'h5);
        mem_wr_ready_i = 1'b1;
        tick();
        check("t3_second", 64'(mem_wr_data_o), 64'h6);
        tick();
        check("t3_empty2", 64'(empty_o), 64'd1);

        // 4: forwarding picks youngest match
        mem_wr_ready_i = 1'b0;
        store(32'h40, 32'hA);
        store(32'h44, 32'hB);
        store(32'h40, 32'hC);
        check("t4_count", 64'(count_o), 64'd3);
        lookup(32'h40, 1'b1, 1'b1, 32'hC, "t4_r40");
        lookup(32'h48, 1'b1, 1'b0, 32'h0, "t4_r48");
        lookup(32'h44, 1'b1, 1'b1, 32'hB, "t4_r44");
        lookup(32'h42, 1'b1, 1'b1, 32'hC, "t4_r42");
        lookup(32'h40, 1'b0, 1'b0, 32'h0, "t4_rdis");

        // 5: store while full with dequeue is dropped; enq+deq keeps count
        store(32'h4C, 32'hD);
        check("t5_full", 64'(full_o), 64'd1);
        mem_wr_ready_i = 1'b1;
        store(32'h50, 32'h99);
        check("t5_ovf", 64'(overflow_o), 64'd1);
        check("t5_count3", 64'(count_o), 64'd3);
        check("t5_head44", 64'(mem_wr_addr_o), 64'h44);
        lookup(32'h50, 1'b1, 1'b0, 32'h0, "t5_dropped");
        tick();
        check("t5_count2", 64'(count_o), 64'd2);
        store(32'h54, 32'hE);
        check("t5_enqdeq", 64'(count_o), 64'd2);
        check("t5_head4c", 64'(mem_wr_addr_o), 64'h4C);
        mem_wr_ready_i = 1'b0;
        store(32'h60, 32'h7);
        store(32'h64, 32'h8);
        check("t5_full2", 64'(full_o), 64'd1);
        store(32'h64, 32'h9);
        check("t5_coal_full_ovf", 64'(overflow_o), 64'd0);
        check("t5_coal_full_cnt", 64'(count_o), 64'd4);
        lookup(32'h64, 1'b1, 1'b1, 32'h9, "t5_r64");
        mem_wr_ready_i = 1'b1;
        tick();
        check("t5_count3b", 64'(count_o), 64'd3);
        check("t5_head54", 64'(mem_wr_data_o), 64'hE);

        // 6: asynchronous reset mid-drain
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_valid", 64'(mem_wr_valid_o), 64'd0);
        check("t6_count", 64'(count_o), 64'd0);
        check("t6_empty", 64'(empty_o), 64'd1);
        tick();
        rst_ni = 1'b1;
        tick();
        check("t6_still_empty", 64'(empty_o), 64'd1);
        store(32'h70, 32'hF);
        check("t6_valid2", 64'(mem_wr_valid_o), 64'd1);
        check("t6_addr", 64'(mem_wr_addr_o), 64'h70);
        check("t6_data", 64'(mem_wr_data_o), 64'hF);
        check("t6_count1", 64'(count_o), 64'd1);
        tick();
        check("t6_drained", 64'(empty_o), 64'd1);
        check("t6_no_stale", 64'(mem_wr_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
